fibo_seq_engine: RTL and testbench
==================================

// Module: fibo_seq_engine
// PURPOSE
//  Self-sequenced, parametrised Fibonacci generator: a controller FSM plus the internal register transfers
//  T<-B, B<-A+B, A<-T, replacing externally driven wrt_addr/rd_addr/alu_opcode sequencing.
//  Start/done handshake, user seeds, streamed terms with index, sticky overflow, optional saturation.
//  Sits between a host controller and downstream display/capture logic.
// PARAMETERS
//  WIDTH  8  term/seed data width in bits
//  CNT_W  4  width of n_terms and term_idx; max run length 2**CNT_W-1 terms
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request run; sampled only in IDLE
//  n_terms    in   CNT_W  number of terms to emit; latched on accepted start
//  seed0      in   WIDTH  term 0; latched on accepted start
//  seed1      in   WIDTH  term 1; latched on accepted start
//  sat_en     in   1      1=saturate to all-ones on carry, 0=wrap mod 2**WIDTH; latched on start
//  busy       out  1      high from cycle after accepted start through DONE cycle
//  term_valid out  1      one-cycle strobe, term/term_idx valid
//  term       out  WIDTH  emitted term value
//  term_idx   out  CNT_W  index of emitted term, 0-based
//  done       out  1      one-cycle strobe, run complete
//  overflow   out  1      sticky: some emitted term overflowed; cleared on next accepted start
//  zero_flag  out  1      registered: last accepted start had n_terms==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output 0; A,B,T,cnt,idx and carry flags 0.
//  Registers: A (older term), B (newer term), T (temp), fa/fb/ft (carry flags travelling with A/B/T),
//  cnt (terms left), idx.
//  States: IDLE, EMIT, T_COPY, T_ADD, T_MOVE, DONE.
//  IDLE: start=1 at edge -> A=seed0, B=seed1, flags=0, cnt=n_terms, idx=0, overflow=0, latch sat_en;
//   zero_flag=(n_terms==0); next EMIT, or DONE if n_terms==0. start=0 -> stay.
//  EMIT: term_valid=1, term=A, term_idx=idx; overflow|=fa; cnt-=1, idx+=1;
//   cnt==1 on entry -> DONE, else T_COPY.
//  T_COPY: T<=B, ft<=fb.
//  T_ADD: {c,s}=A+B (WIDTH+1 bits); B<=(c&sat)?all-ones:s; fb<=c|fa|fb.
//  T_MOVE: A<=T, fa<=ft; next EMIT.
//  DONE: done=1, busy=1 for one cycle; next IDLE. term/term_idx hold last emitted values.
//  Overflow flags only terms actually emitted; carries of the precomputed unemitted term are ignored.
//  Timing: start accepted at edge k -> term i valid in cycle k+1+4i, done in cycle k+4N-2 (N>=1);
//   N=0 -> done in cycle k+1, no term_valid.
//  start while busy: ignored; inputs may change freely after acceptance.
//  Reset mid-run: immediate return to IDLE, no done, outputs 0.
//  start high in DONE cycle: ignored; must be held/reasserted in IDLE.
// TESTING
//  seeds 1,1, N=6, WIDTH=8 -> terms 1,1,2,3,5,8 idx 0..5, 4 cycles apart; done at k+22; overflow=0.
//  seeds 1,1, N=15, sat_en=0 -> idx13=121, idx14=98; overflow rises with idx13 strobe.
//   Same run, sat_en=1 -> idx13=255, idx14=255; overflow=1.
//  N=0 -> done at k+1, zero_flag=1, no term_valid, busy high one cycle.
//  seeds 5,7, N=1 -> single term 5 at k+1, done at k+2.
//   Pulse start again mid-run -> ignored, same output stream.
//  N=6 run, rst_n=0 after 3rd term -> all outputs 0 asynchronously, no done.
//   After release, new start with N=2 seeds 3,4 -> terms 3,4 and done.

Source files
------------

// File: rtl/fibo_seq_engine.sv
// Self-sequenced Fibonacci generator: controller FSM driving T<-B, B<-A+B, A<-T
// transfers, with start/done handshake, streamed terms, sticky overflow and saturation.
module fibo_seq_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             sat_en,
    output logic             busy,
    output logic             term_valid,
    output logic [WIDTH-1:0] term,
    output logic [CNT_W-1:0] term_idx,
    output logic             done,
    output logic             overflow,
    output logic             zero_flag
);

    typedef enum logic [2:0] {
        IDLE,
        EMIT,
        T_COPY,
        T_ADD,
        T_MOVE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] t;
    logic             fa;
    logic             fb;
    logic             ft;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] idx;
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // Outputs are registered on the transition into the state that owns them,
    // so they are visible for exactly the cycle spent in EMIT / DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            t          <= '0;
            fa         <= 1'b0;
            fb         <= 1'b0;
            ft         <= 1'b0;
            sat        <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            term_valid <= 1'b0;
            term       <= '0;
            term_idx   <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            term_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a         <= seed0;
                        b         <= seed1;
                        fa        <= 1'b0;
                        fb        <= 1'b0;
                        ft        <= 1'b0;
                        cnt       <= n_terms;
                        idx       <= '0;
                        overflow  <= 1'b0;
                        sat       <= sat_en;
                        zero_flag <= (n_terms == '0);
                        busy      <= 1'b1;
                        if (n_terms == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= EMIT;
                            term_valid <= 1'b1;
                            term       <= seed0;
                            term_idx   <= '0;
                        end
                    end
                end
                EMIT: begin
                    cnt <= cnt - CNT_W'(1);
                    idx <= idx + CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= T_COPY;
                    end
                end
                T_COPY: begin
                    t     <= b;
                    ft    <= fb;
                    state <= T_ADD;
                end
                T_ADD: begin
                    b     <= (sum[WIDTH] && sat) ? '1 : sum[WIDTH-1:0];
                    fb    <= sum[WIDTH] | fa | fb;
                    state <= T_MOVE;
                end
                T_MOVE: begin
                    a          <= t;
                    fa         <= ft;
                    state      <= EMIT;
                    term_valid <= 1'b1;
                    term       <= t;
                    term_idx   <= idx;
                    overflow   <= overflow | ft;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_seq_engine.sv
// Randomised self-checking bench for fibo_seq_engine against a term-list model.
module tb_fibo_seq_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXV  = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_terms = '0;
    logic [WIDTH-1:0] seed0 = '0;
    logic [WIDTH-1:0] seed1 = '0;
    logic             sat_en = 1'b0;
    logic             busy;
    logic             term_valid;
    logic [WIDTH-1:0] term;
    logic [CNT_W-1:0] term_idx;
    logic             done;
    logic             overflow;
    logic             zero_flag;

    int errors = 0;
    int checks = 0;

    fibo_seq_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .seed0(seed0), .seed1(seed1), .sat_en(sat_en), .busy(busy),
        .term_valid(term_valid), .term(term), .term_idx(term_idx),
        .done(done), .overflow(overflow), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole term list of a run is computed at acceptance;
    // the timeline is derived from the 4-cycle emission cadence.
    int  m_terms[16];
    bit  m_flags[16];
    int  m_n;
    int  m_k;
    int  cyc;
    bit  running;
    bit  m_zero;
    int  prev_term;
    int  prev_idx;

    function automatic int done_rel(input int n);
        return (n == 0) ? 0 : 4 * n - 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running   = 1'b0;
            m_zero    = 1'b0;
            prev_term = 0;
            prev_idx  = 0;
            cyc       = 0;
            m_k       = 0;
            m_n       = 0;
        end else begin
            bit idle_before;
            idle_before = !running || (cyc - m_k) > done_rel(m_n);
            cyc++;
            if (idle_before && start) begin
                if (running && m_n > 0) begin
                    prev_term = m_terms[m_n-1];
                    prev_idx  = m_n - 1;
                end
                m_n     = int'(n_terms);
                m_k     = cyc;
                m_zero  = (n_terms == 0);
                running = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    if (i == 0) begin
                        m_terms[i] = int'(seed0);
                        m_flags[i] = 1'b0;
                    end else if (i == 1) begin
                        m_terms[i] = int'(seed1);
                        m_flags[i] = 1'b0;
                    end else begin
                        int full;
                        bit c;
                        full = m_terms[i-2] + m_terms[i-1];
                        c = full > MAXV;
                        m_terms[i] = c ? (sat_en ? MAXV : full - (MAXV + 1)) : full;
                        m_flags[i] = c | m_flags[i-1] | m_flags[i-2];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int e_busy, e_tv, e_done, e_term, e_idx, e_ovf, e_zero;
        e_busy = 0; e_tv = 0; e_done = 0; e_term = 0;
        e_idx = 0; e_ovf = 0; e_zero = 0;
        if (rst_n && running) begin
            int rel, dr, j;
            rel    = cyc - m_k;
            dr     = done_rel(m_n);
            e_busy = int'(rel <= dr);
            e_done = int'(rel == dr);
            e_zero = int'(m_zero);
            e_term = prev_term;
            e_idx  = prev_idx;
            if (m_n > 0) begin
                e_tv = int'(rel <= 4 * (m_n - 1) && rel % 4 == 0);
                j = rel / 4;
                if (j > m_n - 1) j = m_n - 1;
                e_term = m_terms[j];
                e_idx  = j;
                for (int i = 0; i <= j; i++) e_ovf = e_ovf | int'(m_flags[i]);
            end
        end
        chk("busy", int'(busy), e_busy);
        chk("term_valid", int'(term_valid), e_tv);
        chk("done", int'(done), e_done);
        chk("term", int'(term), e_term);
        chk("term_idx", int'(term_idx), e_idx);
        chk("overflow", int'(overflow), e_ovf);
        chk("zero_flag", int'(zero_flag), e_zero);
    end

    int got[$];
    bit got_ovf[$];

    task automatic run(input int s0, input int s1, input int n, input bit s,
                       input bit noise, input int pulse_at, output int done_at);
        @(negedge clk);
        seed0 = WIDTH'(s0);
        seed1 = WIDTH'(s1);
        n_terms = CNT_W'(n);
        sat_en = s;
        start = 1'b1;
        got.delete();
        got_ovf.delete();
        done_at = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (term_valid) begin
                got.push_back(int'(term));
                got_ovf.push_back(overflow);
            end
            if (done) begin
                done_at = c;
                start = 1'b0;
                break;
            end
            if (noise) begin
                start   = ($urandom_range(0, 5) == 0);
                seed0   = WIDTH'($urandom);
                seed1   = WIDTH'($urandom);
                n_terms = CNT_W'($urandom);
                sat_en  = $urandom_range(0, 1) == 1;
            end else begin
                start = (c == pulse_at);
            end
        end
        if (done_at < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int d;
        int exp6[6];
        exp6 = '{1, 1, 2, 3, 5, 8};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(1, 1, 6, 1'b0, 1'b0, -1, d);
        chk("fib6_done_at", d, 22);
        chk("fib6_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("fib6_term", got[i], exp6[i]);
        chk("fib6_ovf", int'(overflow), 0);

        run(1, 1, 15, 1'b0, 1'b0, -1, d);
        chk("model_t13", m_terms[13], 121);
        chk("model_t14", m_terms[14], 98);
        chk("wrap_count", got.size(), 15);
        if (got.size() == 15) begin
            chk("wrap_t13", got[13], 121);
            chk("wrap_t14", got[14], 98);
            chk("wrap_ovf12", int'(got_ovf[12]), 0);
            chk("wrap_ovf13", int'(got_ovf[13]), 1);
        end

        run(1, 1, 15, 1'b1, 1'b0, -1, d);
        if (got.size() == 15) begin
            chk("sat_t13", got[13], 255);
            chk("sat_t14", got[14], 255);
        end else chk("sat_count", got.size(), 15);
        chk("sat_ovf", int'(overflow), 1);

        run(9, 9, 0, 1'b0, 1'b0, -1, d);
        chk("n0_done_at", d, 1);
        chk("n0_terms", got.size(), 0);
        chk("n0_zero", int'(zero_flag), 1);

        run(5, 7, 1, 1'b0, 1'b0, 1, d);
        chk("n1_done_at", d, 2);
        chk("n1_count", got.size(), 1);
        if (got.size() == 1) chk("n1_term", got[0], 5);

        @(negedge clk);
        seed0 = 1; seed1 = 1; n_terms = 6; sat_en = 0; start = 1'b1;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (term_valid) got.push_back(int'(term));
        end
        chk("rst_pre_terms", got.size(), 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_term", int'(term), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(3, 4, 2, 1'b0, 1'b0, -1, d);
        chk("post_rst_done_at", d, 6);
        chk("post_rst_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("post_rst_t0", got[0], 3);
            chk("post_rst_t1", got[1], 4);
        end

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run($urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 15), $urandom_range(0, 1) == 1, 1'b1, -1, d);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
